// File: rtl/trig_approx_pipe.sv
// trig_approx_pipe: fixed-point sine/cosine Taylor pipeline, seven register
// stages with valid/ready flow control, input clamping and output saturation.
module trig_approx_pipe #(
    parameter int W     = 8,
    parameter int F     = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_range_err,
    output logic             busy
);
    localparam int IW = 2*W + 17;
    localparam int NS = 7;
    localparam longint HPL  = (64'sd15708 * (64'sd1 <<< F) + 64'sd5000) / 64'sd10000;
    localparam longint ONEL = 64'sd1 <<< F;
    localparam longint MAXL = (64'sd1 <<< (W-1)) - 64'sd1;

    localparam logic signed [IW-1:0] C_HP  = IW'(HPL);
    localparam logic signed [IW-1:0] C_NHP = -C_HP;
    localparam logic signed [IW-1:0] C_ONE = IW'(ONEL);
    localparam logic signed [IW-1:0] C_MAX = IW'(MAXL);
    localparam logic signed [IW-1:0] C_MIN = ~C_MAX;
    localparam logic signed [IW-1:0] C_K3  = IW'(10923);
    localparam logic signed [IW-1:0] C_K5  = IW'(546);
    localparam logic signed [IW-1:0] C_KC4 = IW'(2731);

    logic                w_adv;
    logic [NS-1:0]       w_v_nxt;
    logic signed [IW-1:0] w_xs, w_xc;
    logic                w_err;
    logic signed [IW-1:0] w_p2, w_p3, w_p4, w_p5;
    logic signed [IW-1:0] w_t0, w_t1, w_t2;
    logic signed [IW-1:0] w_r;
    logic [W-1:0]        w_y;

    logic [NS-1:0]       r_v;
    logic [NS-1:0]       r_mode;
    logic [NS-1:0]       r_err;
    logic [TAG_W-1:0]    r_tag [NS];
    logic                r_busy;

    logic signed [IW-1:0] r0_x;
    logic signed [IW-1:0] r1_x, r1_p2;
    logic signed [IW-1:0] r2_x, r2_p2, r2_p3, r2_p4;
    logic signed [IW-1:0] r3_x, r3_p2, r3_p3, r3_p4, r3_p5;
    logic signed [IW-1:0] r4_t0, r4_t1, r4_t2;
    logic signed [IW-1:0] r5_r;
    logic [W-1:0]         r6_y;

    assign w_adv   = !r_v[NS-1] | out_ready;
    assign w_v_nxt = w_adv ? {r_v[NS-2:0], in_valid} : r_v;

    assign w_xs = IW'($signed(in_x));

    always_comb begin
        w_xc = w_xs;
        if (w_xs > C_HP)
            w_xc = C_HP;
        else if (w_xs < C_NHP)
            w_xc = C_NHP;
    end

    assign w_err = (w_xs != w_xc);

    assign w_p2 = (r0_x * r0_x) >>> F;
    assign w_p3 = (r1_p2 * r1_x) >>> F;
    assign w_p4 = (r1_p2 * r1_p2) >>> F;
    assign w_p5 = (r2_p4 * r2_x) >>> F;

    // Stage 4 picks the three series terms for the sample's own mode.
    always_comb begin
        w_t0 = r3_x;
        w_t1 = (r3_p3 * C_K3) >>> 16;
        w_t2 = (r3_p5 * C_K5) >>> 16;
        if (r_mode[3]) begin
            w_t0 = C_ONE;
            w_t1 = r3_p2 >>> 1;
            w_t2 = (r3_p4 * C_KC4) >>> 16;
        end
    end

    assign w_r = r4_t0 - r4_t1 + r4_t2;

    always_comb begin
        w_y = r5_r[W-1:0];
        if (r5_r > C_MAX)
            w_y = C_MAX[W-1:0];
        else if (r5_r < C_MIN)
            w_y = C_MIN[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_mode <= '0;
            r_err  <= '0;
            r_busy <= 1'b0;
            for (int k = 0; k < NS; k++)
                r_tag[k] <= '0;
            r0_x  <= '0;
            r1_x  <= '0;
            r1_p2 <= '0;
            r2_x  <= '0;
            r2_p2 <= '0;
            r2_p3 <= '0;
            r2_p4 <= '0;
            r3_x  <= '0;
            r3_p2 <= '0;
            r3_p3 <= '0;
            r3_p4 <= '0;
            r3_p5 <= '0;
            r4_t0 <= '0;
            r4_t1 <= '0;
            r4_t2 <= '0;
            r5_r  <= '0;
            r6_y  <= '0;
        end else begin
            r_v    <= w_v_nxt;
            r_busy <= |w_v_nxt;
            if (w_adv) begin
                r_mode <= {r_mode[NS-2:0], in_mode};
                r_err  <= {r_err[NS-2:0], w_err};
                r_tag[0] <= in_tag;
                for (int k = 1; k < NS; k++)
                    r_tag[k] <= r_tag[k-1];
                r0_x  <= w_xc;
                r1_x  <= r0_x;
                r1_p2 <= w_p2;
                r2_x  <= r1_x;
                r2_p2 <= r1_p2;
                r2_p3 <= w_p3;
                r2_p4 <= w_p4;
                r3_x  <= r2_x;
                r3_p2 <= r2_p2;
                r3_p3 <= r2_p3;
                r3_p4 <= r2_p4;
                r3_p5 <= w_p5;
                r4_t0 <= w_t0;
                r4_t1 <= w_t1;
                r4_t2 <= w_t2;
                r5_r  <= w_r;
                r6_y  <= w_y;
            end
        end
    end

    assign in_ready      = w_adv;
    assign out_valid     = r_v[NS-1];
    assign out_y         = r6_y;
    assign out_mode      = r_mode[NS-1];
    assign out_tag       = r_tag[NS-1];
    assign out_range_err = r_err[NS-1];
    assign busy          = r_busy;

endmodule

// File: doc/trig_approx_pipe.md
TRIG_APPROX_PIPE -- requirements
Module: trig_approx_pipe

Interface
REQ-001 SHALL have parameter W, default 8: total signed width of x and y.
REQ-002 SHALL have parameter F, default 4: fraction bits of x and y (signed fixed point).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each sample.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: input sample present.
REQ-007 SHALL have port in_ready, output, 1: input sample accepted this cycle when in_valid is also 1.
REQ-008 SHALL have port in_x, input, W: signed angle in radians.
REQ-009 SHALL have port in_mode, input, 1: 0 = sine, 1 = cosine.
REQ-010 SHALL have port in_tag, input, TAG_W: opaque tag.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_y, output, W: signed result.
REQ-014 SHALL have port out_mode, output, 1: in_mode of the same sample.
REQ-015 SHALL have port out_tag, output, TAG_W: in_tag of the same sample.
REQ-016 SHALL have port out_range_err, output, 1: in_x was clamped.
REQ-017 SHALL have port busy, output, 1: at least one pipeline stage holds a valid sample.

Function
REQ-018 SHALL use HP = round(1.5708 * 2^F) and ONE = 2^F; xc = in_x clamped to [-HP, +HP].
REQ-019 SHALL set out_range_err = 1 exactly when in_x != xc.
REQ-020 SHALL compute powers with ">>>" (arithmetic shift, floor):
- p2 = (xc*xc)>>>F, p3 = (p2*xc)>>>F
- p4 = (p2*p2)>>>F, p5 = (p4*xc)>>>F
REQ-021 SHALL compute the sine result as r = xc - ((p3*10923)>>>16) + ((p5*546)>>>16).
REQ-022 SHALL compute the cosine result as r = ONE - (p2>>>1) + ((p4*2731)>>>16).
REQ-023 SHALL keep all intermediates signed, at least 2W+17 bits, with no intermediate overflow.
REQ-024 SHALL drive out_y = r saturated to [-2^(W-1), 2^(W-1)-1].
REQ-025 SHALL have a fixed latency of 6 cycles in the absence of stalls: a sample accepted at edge N appears with out_valid=1 after edge N+6.
REQ-026 SHALL have a throughput of one sample per cycle.
REQ-027 SHALL define advance = !out_valid | out_ready.
REQ-028 SHALL drive in_ready = advance, combinationally.
REQ-029 SHALL, when advance=0, hold every stage register (data, mode, tag, err, valid) unchanged.
REQ-030 SHALL let valid bits propagate per stage, so bubbles travel through the pipeline unchanged.
REQ-031 SHALL NOT compress or reorder samples; output order SHALL equal acceptance order.
REQ-032 SHALL treat in_valid=1 with in_ready=0 as no acceptance; the upstream holds the sample.
REQ-033 SHALL, when out_valid=1 and out_ready=1 in the same cycle, retire the result and load the next stage in that same cycle with no bubble.
REQ-034 SHALL hold out_y/out_mode/out_tag/out_range_err stable while out_valid=1 and out_ready=0.
REQ-035 SHALL let mode vary per sample; mixed sine/cosine streams SHALL be exact per sample.
REQ-036 SHALL drive busy = OR of all stage valid bits, registered.

Reset
REQ-037 SHALL, on rst_n low, asynchronously clear all stage valid bits and data registers.
REQ-038 SHALL, while in reset, drive out_valid=0, out_y=0, out_mode=0, out_tag=0, out_range_err=0 and busy=0; in_ready therefore reads 1.
REQ-039 SHALL discard all in-flight samples on reset mid-operation; no stale result SHALL appear after reset release.
REQ-040 SHALL be able to accept a sample at the first rising edge after rst_n deasserts.

Verification (W=8, F=4, HP=25)
REQ-041 SHALL check reset values: x=0 sine -> 0; x=0 cosine -> 16; each result 6 cycles after acceptance, out_range_err=0.
REQ-042 SHALL check basic values: x=16 sine -> 14; x=16 cosine -> 8; x=-16 sine -> -14.
REQ-043 SHALL check clamping: x=127 sine -> 16 with out_range_err=1; x=127 cosine -> 0 with out_range_err=1.
REQ-044 SHALL check back-to-back streaming: 20 consecutive samples with alternating mode and tags 0..15 wrapping, out_ready=1 -> 20 results on consecutive cycles, tags in order, values per REQ-021/022.
REQ-045 SHALL check backpressure: out_ready=0 for 10 cycles mid-stream -> in_ready=0, outputs frozen, no loss or duplication; streaming resumes at full rate when out_ready returns to 1.
REQ-046 SHALL check reset mid-operation: assert rst_n=0 with 4 samples in flight -> out_valid=0 and busy=0 immediately, and no result for those samples after release.
